// File: rtl/wisc_alu_pkg.sv
// Shared ALU encodings and the sequential-multiplier FSM state codes.
package wisc_alu_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'b11011;
  localparam logic [1:0] FUNCT_ADD = 2'b00;

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StRun  = 2'b01;
  localparam logic [1:0] StDone = 2'b10;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add 16x16 multiplier (low 16 product bits) that borrows the shared ALU adder,
// consuming one multiplier bit per cycle and requesting the ALU only when it must add.
module alu_mul_seq
  import wisc_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [4:0]       alu_opcode,
  output logic [1:0]       alu_funct,
  output logic [WIDTH-1:0] alu_rs,
  output logic [WIDTH-1:0] alu_rt,
  input  logic [WIDTH-1:0] alu_res
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d     = '0;
          mcand_d   = a;
          mplier_d  = b;
          product_d = '0;
          state_d   = (b != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        // A set multiplier bit must wait for the grant; a clear bit shifts for free.
        if (!mplier_q[0] || alu_gnt) begin
          if (mplier_q[0]) begin
            acc_d = alu_res;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (mplier_d == '0) begin
            product_d = acc_d;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end

  // Moore request: never looks at alu_gnt, so no combinational loop with the arbiter.
  assign alu_req    = (state_q == StRun) && mplier_q[0];
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign product    = product_q;
  assign alu_opcode = OPC_RTYPE;
  assign alu_funct  = FUNCT_ADD;
  assign alu_rs     = acc_q;
  assign alu_rt     = mcand_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed scenarios plus randomized traffic
// checked every cycle against an arithmetic model of the multiply.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        alu_req;
  logic        alu_gnt;
  logic [4:0]  alu_opcode;
  logic [1:0]  alu_funct;
  logic [15:0] alu_rs;
  logic [15:0] alu_rt;
  logic [15:0] alu_res;

  int checks;
  int failures;

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_opcode (alu_opcode),
    .alu_funct  (alu_funct),
    .alu_rs     (alu_rs),
    .alu_rt     (alu_rt),
    .alu_res    (alu_res)
  );

  // Shared ALU stand-in: combinational 16-bit add.
  assign alu_res = alu_rs + alu_rt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 multiplying, 2 done; m_k is the multiplier bit in use.
  int          m_ph;
  int          m_k;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [15:0] m_prod;
  logic [15:0] m_final;
  logic        m_zero;
  logic        chk_en;
  logic [31:0] exp_acc;
  logic [31:0] exp_rt;

  initial begin
    m_ph   = 0;
    m_k    = 0;
    m_a    = '0;
    m_b    = '0;
    m_prod = '0;
    m_final = '0;
    m_zero = 1'b1;
    chk_en = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_ph   <= 0;
      m_prod <= '0;
      m_zero <= 1'b1;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_a     <= a;
          m_b     <= b;
          m_k     <= 0;
          m_final <= a * b;
          m_prod  <= '0;
          m_zero  <= 1'b0;
          m_ph    <= (b == 16'h0) ? 2 : 1;
        end
        1: if (!m_b[m_k] || alu_gnt) begin
          m_k <= m_k + 1;
          if ((m_b >> (m_k + 1)) == 16'h0) begin
            m_ph   <= 2;
            m_prod <= m_final;
          end
        end
        default: m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("opcode", 32'(alu_opcode), 32'h1B);
      chk("funct", 32'(alu_funct), 32'h0);
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("done", 32'(done), 32'(m_ph == 2));
      chk("product", 32'(product), 32'(m_prod));
      if (m_ph == 1) begin
        chk("alu_req", 32'(alu_req), 32'(m_b[m_k]));
        if (m_b[m_k]) begin
          // Partial product of the multiplier bits already consumed, and a shifted by k.
          exp_acc = {16'h0, m_a} * ({16'h0, m_b} & ((32'h1 << m_k) - 32'h1));
          exp_rt  = {16'h0, m_a} << m_k;
          chk("alu_rs", 32'(alu_rs), {16'h0, exp_acc[15:0]});
          chk("alu_rt", 32'(alu_rt), {16'h0, exp_rt[15:0]});
        end
      end else begin
        chk("alu_req_off", 32'(alu_req), 32'h0);
      end
      if (m_ph == 0 && m_zero) begin
        chk("rs_after_rst", 32'(alu_rs), 32'h0);
        chk("rt_after_rst", 32'(alu_rt), 32'h0);
      end
    end
  end

  // Runs one operation starting in cycle 0; grant is withheld in cycles stall_lo..stall_hi.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input int stall_lo, input int stall_hi,
                        input int restart_cyc, input int rst_cyc,
                        output int done_cyc, output int req_cnt, output logic [31:0] req_vec,
                        output logic [15:0] prod, output logic busy_ar, output logic [15:0] prod_ar);
    done_cyc = -1;
    req_cnt  = 0;
    req_vec  = '0;
    prod     = '0;
    busy_ar  = 1'b1;
    prod_ar  = 16'hDEAD;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #2;
      start   = (n == 0) || (n == restart_cyc);
      a       = (n == 0) ? ta : 16'h0001;
      b       = (n == 0) ? tb_v : 16'h0001;
      rst     = (n == rst_cyc);
      alu_gnt = !(n >= stall_lo && n <= stall_hi);
      @(negedge clk);
      if (alu_req) begin
        req_cnt++;
        req_vec[n] = 1'b1;
      end
      if (n == rst_cyc + 1) begin
        busy_ar = busy;
        prod_ar = product;
      end
      if (done && done_cyc < 0) begin
        done_cyc = n;
        prod     = product;
      end
      if (done_cyc >= 0 && n > done_cyc) break;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  int          d_cyc;
  int          r_cnt;
  logic [31:0] r_vec;
  logic [15:0] prd;
  logic        b_ar;
  logic [15:0] p_ar;
  logic [31:0] rnd;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    alu_gnt  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_product", 32'(product), 32'h0);
    chk("rst_req", 32'(alu_req), 32'h0);
    chk("rst_rs", 32'(alu_rs), 32'h0);
    chk("rst_rt", 32'(alu_rt), 32'h0);

    run_op(16'd3, 16'd5, -1, -1, -1, -1, d_cyc, r_cnt, r_vec, prd, b_ar, p_ar);
    chk("t1_done_cyc", 32'(d_cyc), 32'd4);
    chk("t1_product", 32'(prd), 32'd15);
    chk("t1_req_pattern", {29'h0, r_vec[3:1]}, 32'b101);

    run_op(16'h1234, 16'h0000, -1, -1, -1, -1, d_cyc, r_cnt, r_vec, prd, b_ar, p_ar);
    chk("t2_done_cyc", 32'(d_cyc), 32'd1);
    chk("t2_product", 32'(prd), 32'h0);
    chk("t2_req_cnt", 32'(r_cnt), 32'd0);

    run_op(16'hFFFF, 16'hFFFF, -1, -1, -1, -1, d_cyc, r_cnt, r_vec, prd, b_ar, p_ar);
    chk("t3_done_cyc", 32'(d_cyc), 32'd17);
    chk("t3_product", 32'(prd), 32'h0001);
    chk("t3_req_cnt", 32'(r_cnt), 32'd16);

    run_op(16'd7, 16'd3, 1, 2, -1, -1, d_cyc, r_cnt, r_vec, prd, b_ar, p_ar);
    chk("t4_done_cyc", 32'(d_cyc), 32'd5);
    chk("t4_product", 32'(prd), 32'd21);
    chk("t4_req_held", {28'h0, r_vec[4:1]}, 32'hF);

    run_op(16'd9, 16'h00F0, -1, -1, 3, -1, d_cyc, r_cnt, r_vec, prd, b_ar, p_ar);
    chk("t5_done_cyc", 32'(d_cyc), 32'd9);
    chk("t5_product", 32'(prd), 32'h0870);

    run_op(16'd5, 16'h8000, -1, -1, -1, 6, d_cyc, r_cnt, r_vec, prd, b_ar, p_ar);
    chk("t6_busy_after_rst", 32'(b_ar), 32'h0);
    chk("t6_product_after_rst", 32'(p_ar), 32'h0);
    chk("t6_no_done", 32'(d_cyc), 32'hFFFF_FFFF);

    repeat (3000) begin
      @(posedge clk);
      #2;
      rst     = ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 2) == 0);
      rnd     = $urandom;
      a       = rnd[15:0];
      rnd     = $urandom;
      b       = rnd[15:0] >> $urandom_range(0, 16);
      alu_gnt = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #2;
    start = 1'b0;
    rst   = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
